// File: rtl/mult_sched.sv
// mult_sched -- two-requester round-robin scheduler in front of an external
// multi-cycle multiplier.
//
// Build option: define MULT_SCHED_TIMEOUT_EN to abort a RUN phase that sees no
// m_finish within N+2 cycles (result forced to 0, err pulsed with ack).
// Without it the RUN phase waits indefinitely and err is tied low.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req[1:0]          per-requester request
//   a0,b0 / a1,b1     requester 0 / 1 operands (N bits)
//   ack[1:0]          one-cycle pulse when that requester's result is on res
//   res[2N-1:0]       last captured product (held between captures)
//   busy              high while an operation is in progress
//   err               timeout flag, pulsed together with ack
//   m_start           multiplier control: 0 = load operands, 1 = run
//   m_a, m_b          operands presented to the multiplier
//   m_out, m_finish   multiplier product and completion flag
module mult_sched #(
  parameter int unsigned N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [N-1:0]     a0,
  input  logic [N-1:0]     b0,
  input  logic [N-1:0]     a1,
  input  logic [N-1:0]     b1,
  output logic [1:0]       ack,
  output logic [2*N-1:0]   res,
  output logic             busy,
  output logic             err,
  output logic             m_start,
  output logic [N-1:0]     m_a,
  output logic [N-1:0]     m_b,
  input  logic [2*N-1:0]   m_out,
  input  logic             m_finish
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t state;
  logic   ptr;    // last-served requester
  logic   g;      // requester currently being served
  logic   grant;

  // On a tie the requester that was not served last wins; otherwise the
  // single active requester is taken.
  always_comb begin
    grant = (req == 2'b11) ? ~ptr : req[1];
  end

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(N + 2);
  localparam logic [TW-1:0] TLAST = TW'(N + 1);
  logic [TW-1:0] tcnt;
  logic          timed_out;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      m_start <= 1'b0;
      m_a     <= '0;
      m_b     <= '0;
      ack     <= '0;
      res     <= '0;
      busy    <= 1'b0;
      ptr     <= 1'b1;
      g       <= 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
      err       <= 1'b0;
      tcnt      <= '0;
      timed_out <= 1'b0;
`endif
    end else begin
      ack <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            g     <= grant;
            m_a   <= grant ? a1 : a0;
            m_b   <= grant ? b1 : b0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          // m_start was low for this cycle, so the multiplier has loaded
          // the latched operands; release it to run.
          m_start <= 1'b1;
          state   <= RUN;
`ifdef MULT_SCHED_TIMEOUT_EN
          tcnt      <= '0;
          timed_out <= 1'b0;
`endif
        end
        RUN: begin
          if (m_finish) begin
            res     <= m_out;
            m_start <= 1'b0;
            state   <= DONE;
          end
`ifdef MULT_SCHED_TIMEOUT_EN
          else if (tcnt == TLAST) begin
            res       <= '0;
            m_start   <= 1'b0;
            timed_out <= 1'b1;
            state     <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        DONE: begin
          ack   <= g ? 2'b10 : 2'b01;
          ptr   <= g;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef MULT_SCHED_TIMEOUT_EN
          err <= timed_out;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
module tb_mult_sched;

  localparam int N = 8;

  logic             clk;
  logic             reset;
  logic [1:0]       req;
  logic [N-1:0]     a0, b0, a1, b1;
  logic [1:0]       ack;
  logic [2*N-1:0]   res;
  logic             busy, err, m_start;
  logic [N-1:0]     m_a, m_b;
  logic [2*N-1:0]   m_out;
  logic             m_finish;

  mult_sched #(.N(N)) dut (
    .clk(clk), .reset(reset), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack(ack), .res(res), .busy(busy), .err(err),
    .m_start(m_start), .m_a(m_a), .m_b(m_b),
    .m_out(m_out), .m_finish(m_finish)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- external shift-add multiplier model ----------------
  logic [2*N-1:0] mc, acc;
  logic [N-1:0]   mp;
  int             mcnt;
  logic           fin;
  logic           glitch_en = 1'b0;
  logic           force_low = 1'b0;

  assign m_out    = acc;
  assign m_finish = fin;

  always @(posedge clk) begin
    if (!m_start) begin
      mc   <= {{N{1'b0}}, m_a};
      mp   <= m_b;
      acc  <= '0;
      mcnt <= 0;
      // Spurious completion pulses while the scheduler is idle or loading.
      fin  <= glitch_en && !busy && ($urandom_range(0, 1) == 1);
    end else if (mcnt < N) begin
      if (mp[0]) acc <= acc + mc;
      mc   <= mc << 1;
      mp   <= mp >> 1;
      mcnt <= mcnt + 1;
      fin  <= (mcnt == N - 1) && !force_low;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int             k;
    logic [2*N-1:0] prod;
    logic           err;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic ptr_m   = 1'b1;
  int   free_at = 0;
  int   last_g  = -1000;
  int   lat_m   = N + 3;
  logic tmo_m   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Server with a fixed service time: a request seen while free is granted
  // (round-robin on ties) and answered N+3 edges later; the server is free
  // again one edge after the answer.
  task automatic step(input logic [1:0] r, input logic [N-1:0] x0, input logic [N-1:0] y0,
                      input logic [N-1:0] x1, input logic [N-1:0] y1);
    int   n;
    exp_t e;
    n = cyc + 1;
    if (r != 2'b00 && n >= free_at) begin
      e.k    = (r == 2'b11) ? (ptr_m ? 0 : 1) : (r[1] ? 1 : 0);
      e.err  = tmo_m;
      e.prod = tmo_m ? '0 : (e.k == 1 ? (2*N)'(x1) * (2*N)'(y1) : (2*N)'(x0) * (2*N)'(y0));
      e.cyc  = n + (tmo_m ? N + 4 : N + 3);
      sb.push_back(e);
      ptr_m   = (e.k == 1);
      last_g  = n;
      lat_m   = e.cyc - n;
      free_at = e.cyc + 1;
    end
    req = r; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++)
      step(2'b00, N'($urandom), N'($urandom), N'($urandom), N'($urandom));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_res", 32'(res), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_m_start", 32'(m_start), 32'h0);
    chk("rst_m_a", 32'(m_a), 32'h0);
    chk("rst_m_b", 32'(m_b), 32'h0);
    req = 2'b00;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    sb.delete();
    ptr_m   = 1'b1;
    free_at = cyc + 1;
    last_g  = -1000;
  endtask

  // Monitor: checks busy every cycle and pops an expectation on every ack.
  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 32'(busy), 32'((cyc >= last_g) && (cyc < last_g + lat_m)));
      if (ack != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_bit", 32'(ack), 32'(1 << e.k));
          chk("res", 32'(res), 32'(e.prod));
          chk("err", 32'(err), 32'(e.err));
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("err_idle", 32'(err), 32'h0);
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          chk("ack_missing", 32'(ack), 32'(1 << sb[0].k));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    req = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // single request
    step(2'b01, 8'd13, 8'd11, 8'd0, 8'd0);
    idle(14);

    // tie straight after reset: requester 0 first
    do_reset();
    for (int i = 0; i < 13; i++) step(2'b11, 8'd2, 8'd3, 8'd4, 8'd5);
    idle(14);

    // continuous contention with changing operands
    for (int i = 0; i < 4 * (N + 4); i++)
      step(2'b11, N'($urandom), N'($urandom), N'($urandom), N'($urandom));
    idle(14);

    // maximum operands on requester 1
    step(2'b10, 8'd0, 8'd0, 8'd255, 8'd255);
    idle(14);

    // reset in the middle of RUN, then a fresh request
    step(2'b01, 8'd100, 8'd200, 8'd0, 8'd0);
    idle(5);
    do_reset();
    step(2'b01, 8'd7, 8'd9, 8'd0, 8'd0);
    idle(14);

    // random traffic with spurious m_finish pulses outside RUN
    glitch_en = 1'b1;
    for (int i = 0; i < 600; i++)
      step(2'($urandom), N'($urandom), N'($urandom), N'($urandom), N'($urandom));
    glitch_en = 1'b0;
    idle(14);

`ifdef MULT_SCHED_TIMEOUT_EN
    // multiplier never finishes: expect err with res cleared
    do_reset();
    force_low = 1'b1;
    tmo_m     = 1'b1;
    step(2'b10, 8'd0, 8'd0, 8'd33, 8'd44);
    idle(16);
    tmo_m     = 1'b0;
    force_low = 1'b0;
    step(2'b01, 8'd6, 8'd7, 8'd0, 8'd0);
    idle(14);
`endif

    for (int i = 0; i < 50 && sb.size() > 0; i++) idle(1);
    if (sb.size() > 0) chk("drain", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
